// File: rtl/deskew_registers_if.sv
// Bus bundle for deskew_registers: skewed lane inputs, aligned vector outputs.
// DESKEW_CHECK_EN adds the sticky skew_err output.
interface deskew_registers_if #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 16,
    parameter int ROWS       = 16
);
    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                    en;
    logic                    clear;
    logic [N-1:0]            in_valid;
    logic [DATA_WIDTH*N-1:0] packed_din;
    logic                    out_valid;
    logic [DATA_WIDTH*N-1:0] packed_dout;
    logic [CW-1:0]           out_row_idx;
    logic                    tile_done;
`ifdef DESKEW_CHECK_EN
    logic                    skew_err;

    modport master (output en, clear, in_valid, packed_din,
                    input  out_valid, packed_dout, out_row_idx, tile_done, skew_err);
    modport slave  (input  en, clear, in_valid, packed_din,
                    output out_valid, packed_dout, out_row_idx, tile_done, skew_err);
`else
    modport master (output en, clear, in_valid, packed_din,
                    input  out_valid, packed_dout, out_row_idx, tile_done);
    modport slave  (input  en, clear, in_valid, packed_din,
                    output out_valid, packed_dout, out_row_idx, tile_done);
`endif
endinterface

// File: rtl/deskew_registers.sv
// Output deskew for the systolic array: lane i is delayed N-1-i cycles so each row
// leaves as one aligned vector; counts rows per tile. Optional DESKEW_CHECK_EN skew checker.
module deskew_registers #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 16,
    parameter int ROWS       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    deskew_registers_if.slave bus
);
    localparam int             CW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int             VD       = N - 1;
    localparam logic [CW-1:0]  LAST_ROW = CW'(ROWS - 1);

    logic [VD-1:0]                  vld_pipe_q;
    logic [N-1:0][DATA_WIDTH-1:0]   lane_tail;
    logic                           load;

    logic                    out_valid_q, out_valid_d;
    logic                    tile_done_q, tile_done_d;
    logic [DATA_WIDTH*N-1:0] dout_q, dout_d;
    logic [CW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           next_q, next_d;

    // Per-lane data delay; data shifts on every enabled edge regardless of valid.
    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i == N - 1) begin : g_direct
            assign lane_tail[i] = bus.packed_din[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_chain
            localparam int D = N - 1 - i;
            logic [D-1:0][DATA_WIDTH-1:0] dly_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dly_q <= '0;
                end else if (bus.en) begin
                    dly_q[0] <= bus.packed_din[i*DATA_WIDTH +: DATA_WIDTH];
                    for (int k = 1; k < D; k++) dly_q[k] <= dly_q[k-1];
                end
            end

            assign lane_tail[i] = dly_q[D-1];
        end
    end

    // Only lane 0's valid is tracked; vld_pipe_q[k] is in_valid[0] delayed k+1 enabled edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
        end else if (bus.clear) begin
            vld_pipe_q <= '0;
        end else if (bus.en) begin
            vld_pipe_q[0] <= bus.in_valid[0];
            for (int k = 1; k < VD; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
        end
    end

    assign load = bus.en && !bus.clear && vld_pipe_q[VD-1];

    always_comb begin
        out_valid_d = 1'b0;
        tile_done_d = 1'b0;
        dout_d      = dout_q;
        idx_d       = idx_q;
        next_d      = next_q;
        if (bus.clear) begin
            idx_d  = '0;
            next_d = '0;
        end else if (load) begin
            out_valid_d = 1'b1;
            tile_done_d = (next_q == LAST_ROW);
            dout_d      = lane_tail;
            idx_d       = next_q;
            next_d      = (next_q == LAST_ROW) ? '0 : next_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            tile_done_q <= 1'b0;
            dout_q      <= '0;
            idx_q       <= '0;
            next_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            tile_done_q <= tile_done_d;
            dout_q      <= dout_d;
            idx_q       <= idx_d;
            next_q      <= next_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.tile_done   = tile_done_q;
    assign bus.packed_dout = dout_q;
    assign bus.out_row_idx = idx_q;

`ifdef DESKEW_CHECK_EN
    // Reference chain ignores clear so lanes of a flushed row still line up afterwards.
    logic [VD-1:0] ref_q;
    logic          skew_err_q;
    logic          mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q <= '0;
        end else if (bus.en) begin
            ref_q[0] <= bus.in_valid[0];
            for (int k = 1; k < VD; k++) ref_q[k] <= ref_q[k-1];
        end
    end

    assign mismatch = |(bus.in_valid[N-1:1] ^ ref_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   skew_err_q <= 1'b0;
        else if (bus.clear)           skew_err_q <= 1'b0;
        else if (bus.en && mismatch)  skew_err_q <= 1'b1;
    end

    assign bus.skew_err = skew_err_q;
`else
    logic unused_lane_valid;
    assign unused_lane_valid = ^bus.in_valid[N-1:1];
`endif
endmodule
